// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL acquisition controller.
package pll_pkg;

  localparam int FREQ_W = 32;
  localparam int ERR_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SWEEP = 3'd1,
    ST_PULL  = 3'd2,
    ST_TRACK = 3'd3,
    ST_FAIL  = 3'd4
  } state_t;

  localparam logic [1:0] GAIN_OFF    = 2'd0;
  localparam logic [1:0] GAIN_COARSE = 2'd1;
  localparam logic [1:0] GAIN_FINE   = 2'd2;

endpackage

// File: rtl/pll_err_qual.sv
// Phase-error qualifier: saturating magnitude, lock threshold compare and
// consecutive in-lock / out-of-lock run counters. The hit outputs flag the
// tick on which a run reaches its target count, so the controller can act
// on that same tick. clr wipes both runs (asserted on every state change).
module pll_err_qual
  import pll_pkg::*;
#(
  parameter int LOCK_THR   = 512,
  parameter int LOCK_CNT   = 32,
  parameter int UNLOCK_CNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    clr,
  input  logic signed [ERR_W-1:0] error_i,
  output logic                    lock_hit,
  output logic                    unlock_hit
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  localparam logic [ERR_W-1:0] THR       = ERR_W'(LOCK_THR);
  localparam logic [LW-1:0]   LOCK_MAX   = LW'(LOCK_CNT);
  localparam logic [LW-1:0]   LOCK_LAST  = LW'(LOCK_CNT - 1);
  localparam logic [UW-1:0]   UNLK_MAX   = UW'(UNLOCK_CNT);
  localparam logic [UW-1:0]   UNLK_LAST  = UW'(UNLOCK_CNT - 1);

  // Most-negative input maps to the most-positive magnitude so it can never
  // wrap into a small (in-lock) value.
  function automatic logic [ERR_W-1:0] sat_abs(input logic signed [ERR_W-1:0] e);
    if (e == {1'b1, {(ERR_W-1){1'b0}}}) return {1'b0, {(ERR_W-1){1'b1}}};
    else if (e[ERR_W-1])                return $unsigned(-e);
    else                                return $unsigned(e);
  endfunction

  logic [ERR_W-1:0] mag;
  logic             in_lock;
  logic [LW-1:0]    lock_run;
  logic [UW-1:0]    unlock_run;

  assign mag        = sat_abs(error_i);
  assign in_lock    = (mag <= THR);
  assign lock_hit   = tick & in_lock & (lock_run >= LOCK_LAST);
  assign unlock_hit = tick & ~in_lock & (unlock_run >= UNLK_LAST);

  // Run counters: advance only on tick, saturate at their targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_run   <= '0;
      unlock_run <= '0;
    end else if (clr) begin
      lock_run   <= '0;
      unlock_run <= '0;
    end else if (tick) begin
      if (in_lock) begin
        lock_run   <= (lock_run == LOCK_MAX) ? lock_run : lock_run + 1'b1;
        unlock_run <= '0;
      end else begin
        lock_run   <= '0;
        unlock_run <= (unlock_run == UNLK_MAX) ? unlock_run : unlock_run + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pll_acq_ctrl.sv
// PLL acquisition controller: frequency sweep, pull-in and tracking FSM.
// Optional macro PLL_ACQ_STATS_EN adds lock_events_o, a saturating count
// of entries into TRACK that clears only on rst.
module pll_acq_ctrl
  import pll_pkg::*;
#(
  parameter logic [FREQ_W-1:0] F_START = 32'h0100_0000,
  parameter logic [FREQ_W-1:0] F_STOP  = 32'h0400_0000,
  parameter logic [FREQ_W-1:0] F_STEP  = 32'h0010_0000,
  parameter int DWELL      = 64,
  parameter int LOCK_THR   = 512,
  parameter int LOCK_CNT   = 32,
  parameter int UNLOCK_CNT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    start_i,
  input  logic                    abort_i,
  input  logic signed [ERR_W-1:0] error_i,
  output logic [FREQ_W-1:0]       freq_o,
  output logic [1:0]              gain_sel_o,
  output logic [2:0]              state_o,
  output logic                    locked_o,
  output logic                    fail_o,
  output logic                    busy_o
`ifdef PLL_ACQ_STATS_EN
  ,
  output logic [15:0]             lock_events_o
`endif
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

  state_t            state, state_next;
  logic [FREQ_W-1:0] freq_next;
  logic [FREQ_W:0]   freq_sum;
  logic [DW_W-1:0]   dwell, dwell_next;
  logic [1:0]        gain_next;
  logic              locked_next, fail_next, busy_next;
  logic              qual_clr, lock_hit, unlock_hit;

  // One extra bit so the overshoot test cannot be fooled by 32-bit wrap.
  assign freq_sum = {1'b0, freq_o} + {1'b0, F_STEP};
  assign qual_clr = (state_next != state);
  assign state_o  = state;

  pll_err_qual #(
    .LOCK_THR   (LOCK_THR),
    .LOCK_CNT   (LOCK_CNT),
    .UNLOCK_CNT (UNLOCK_CNT)
  ) u_qual (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .clr        (qual_clr),
    .error_i    (error_i),
    .lock_hit   (lock_hit),
    .unlock_hit (unlock_hit)
  );

  // Next-state, sweep word, dwell counter and decoded status flags.
  always_comb begin
    state_next = state;
    freq_next  = freq_o;
    dwell_next = dwell;
    if (abort_i) begin
      state_next = ST_IDLE;
      freq_next  = F_START;
    end else begin
      case (state)
        ST_IDLE, ST_FAIL: if (start_i) state_next = ST_SWEEP;
        ST_SWEEP: begin
          if (lock_hit) begin
            state_next = ST_PULL;
          end else if (tick) begin
            if (dwell == DWELL_LAST) begin
              dwell_next = '0;
              if (freq_sum > {1'b0, F_STOP}) begin
                state_next = ST_FAIL;
                freq_next  = F_START;
              end else begin
                freq_next = freq_sum[FREQ_W-1:0];
              end
            end else begin
              dwell_next = dwell + 1'b1;
            end
          end
        end
        ST_PULL: begin
          if (lock_hit)        state_next = ST_TRACK;
          else if (unlock_hit) state_next = ST_SWEEP;
        end
        ST_TRACK: begin
          if (unlock_hit) begin
            state_next = ST_SWEEP;
            freq_next  = F_START;
          end
        end
        default: begin
          state_next = ST_IDLE;
          freq_next  = F_START;
        end
      endcase
    end
    if (state_next != state) dwell_next = '0;

    gain_next   = GAIN_OFF;
    locked_next = 1'b0;
    fail_next   = 1'b0;
    busy_next   = 1'b0;
    case (state_next)
      ST_SWEEP: busy_next = 1'b1;
      ST_PULL: begin
        gain_next = GAIN_COARSE;
        busy_next = 1'b1;
      end
      ST_TRACK: begin
        gain_next   = GAIN_FINE;
        locked_next = 1'b1;
        busy_next   = 1'b1;
      end
      ST_FAIL: fail_next = 1'b1;
      default: ;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      freq_o     <= F_START;
      dwell      <= '0;
      gain_sel_o <= GAIN_OFF;
      locked_o   <= 1'b0;
      fail_o     <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_next;
      freq_o     <= freq_next;
      dwell      <= dwell_next;
      gain_sel_o <= gain_next;
      locked_o   <= locked_next;
      fail_o     <= fail_next;
      busy_o     <= busy_next;
    end
  end

`ifdef PLL_ACQ_STATS_EN
  // Saturating count of entries into TRACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_events_o <= '0;
    end else if (state_next == ST_TRACK && state != ST_TRACK && lock_events_o != 16'hFFFF) begin
      lock_events_o <= lock_events_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_acq_ctrl.sv
// Testbench for pll_acq_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural reference model.
module tb_pll_acq_ctrl;

  localparam logic [31:0] F_START = 32'h0100_0000;
  localparam logic [31:0] F_STOP  = 32'h0400_0000;
  localparam logic [31:0] F_STEP  = 32'h0010_0000;
  localparam int DWELL = 64, LOCK_THR = 512, LOCK_CNT = 32, UNLOCK_CNT = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick, start_i, abort_i;
  logic signed [15:0] error_i;
  logic [31:0]        freq_o;
  logic [1:0]         gain_sel_o;
  logic [2:0]         state_o;
  logic               locked_o, fail_o, busy_o;
`ifdef PLL_ACQ_STATS_EN
  logic [15:0]        lock_events_o;
`endif

  pll_acq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .error_i    (error_i),
    .freq_o     (freq_o),
    .gain_sel_o (gain_sel_o),
    .state_o    (state_o),
    .locked_o   (locked_o),
    .fail_o     (fail_o),
    .busy_o     (busy_o)
`ifdef PLL_ACQ_STATS_EN
    ,
    .lock_events_o (lock_events_o)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp_v);
    end
  endtask

  // Reference model. States use the published encoding 0..4; run lengths
  // are plain unbounded integers and the sweep word is held in 64 bits.
  int     m_state;
  longint m_freq;
  int     m_dwell, m_in_run, m_out_run, m_events;

  task automatic model_reset();
    m_state = 0; m_freq = F_START; m_dwell = 0;
    m_in_run = 0; m_out_run = 0; m_events = 0;
  endtask

  task automatic model_cycle(input bit st, input bit ab, input bit tk, input int err);
    int mag, nxt;
    mag = (err < 0) ? -err : err;
    if (mag > 32767) mag = 32767;
    if (tk) begin
      if (mag <= LOCK_THR) begin m_in_run++; m_out_run = 0; end
      else begin m_out_run++; m_in_run = 0; end
    end
    nxt = m_state;
    if (ab) begin
      nxt = 0; m_freq = F_START;
    end else begin
      case (m_state)
        0, 4: if (st) nxt = 1;
        1: if (tk) begin
          if (m_in_run >= LOCK_CNT) nxt = 2;
          else begin
            m_dwell++;
            if (m_dwell == DWELL) begin
              m_dwell = 0;
              if (m_freq + F_STEP > F_STOP) begin nxt = 4; m_freq = F_START; end
              else m_freq = m_freq + F_STEP;
            end
          end
        end
        2: if (tk) begin
          if (m_in_run >= LOCK_CNT) nxt = 3;
          else if (m_out_run >= UNLOCK_CNT) nxt = 1;
        end
        3: if (tk && m_out_run >= UNLOCK_CNT) begin nxt = 1; m_freq = F_START; end
        default: nxt = 0;
      endcase
    end
    if (nxt != m_state) begin
      m_in_run = 0; m_out_run = 0; m_dwell = 0;
      if (nxt == 3 && m_events < 65535) m_events++;
    end
    m_state = nxt;
  endtask

  task automatic compare_all();
    chk("state", 32'(state_o), 32'(m_state));
    chk("freq", freq_o, m_freq[31:0]);
    chk("gain", 32'(gain_sel_o), (m_state == 2) ? 32'd1 : (m_state == 3) ? 32'd2 : 32'd0);
    chk("locked", 32'(locked_o), 32'(m_state == 3));
    chk("fail", 32'(fail_o), 32'(m_state == 4));
    chk("busy", 32'(busy_o), 32'(m_state >= 1 && m_state <= 3));
`ifdef PLL_ACQ_STATS_EN
    chk("lock_events", 32'(lock_events_o), 32'(m_events));
`endif
  endtask

  // One clock: drive at negedge, model at posedge, compare 1 ns later.
  task automatic cyc(input bit st, input bit ab, input bit tk, input int err);
    start_i = st; abort_i = ab; tick = tk; error_i = 16'(err);
    @(posedge clk);
    model_cycle(st, ab, tk, err);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd0);
    chk({tag, "_freq"}, freq_o, F_START);
    chk({tag, "_gain"}, 32'(gain_sel_o), 32'd0);
    chk({tag, "_flags"}, {29'd0, locked_o, fail_o, busy_o}, 32'd0);
  endtask

  int     n;
  logic [31:0] max_freq;
  bit     mode_in;
  int     err;

  initial begin
    rst = 1'b1; tick = 1'b0; start_i = 1'b0; abort_i = 1'b0; error_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

`ifdef PLL_ACQ_STATS_EN
    // Three lock / unlock cycles.
    cyc(1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 2 * LOCK_CNT; i++) cyc(0, 0, 1, 0);
      chk("stats_track", 32'(state_o), 32'd3);
      for (int i = 0; i < UNLOCK_CNT; i++) cyc(0, 0, 1, 3000);
    end
    chk("stats_events", 32'(lock_events_o), 32'd3);
    cyc(0, 1, 0, 0);
`endif

    // Full sweep without lock runs out of words.
    cyc(1, 0, 0, 0);
    n = 0; max_freq = '0;
    while (n < 4000 && state_o != 3'd4) begin
      cyc(0, 0, 1, 2000);
      if (freq_o > max_freq && state_o == 3'd1) max_freq = freq_o;
      n++;
    end
    chk("sweep_ticks", 32'(n), 32'd3136);
    chk("sweep_max_freq", max_freq, 32'h0400_0000);
    chk("sweep_fail_flag", 32'(fail_o), 32'd1);
    chk("sweep_fail_freq", freq_o, 32'h0100_0000);

    // Lock found on the third sweep word, pull-in then track.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 162; i++) cyc(0, 0, 1, (i >= 130) ? 100 : 2000);
    chk("pull_state", 32'(state_o), 32'd2);
    chk("pull_freq", freq_o, 32'h0120_0000);
    for (int i = 0; i < LOCK_CNT; i++) cyc(0, 0, 1, 100);
    chk("track_state", 32'(state_o), 32'd3);
    chk("track_locked", 32'(locked_o), 32'd1);
    chk("track_gain", 32'(gain_sel_o), 32'd2);

    // Seven bad ticks then a good one holds lock; eight in a row drops it.
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1000);
    cyc(0, 0, 1, 0);
    chk("track_hold", 32'(state_o), 32'd3);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 1000);
    chk("track_7bad", 32'(state_o), 32'd3);
    cyc(0, 0, 1, 1000);
    chk("unlock_state", 32'(state_o), 32'd1);
    chk("unlock_freq", freq_o, 32'h0100_0000);
    chk("unlock_locked", 32'(locked_o), 32'd0);

    // Most-negative error must read as out-of-lock.
    for (int i = 0; i < 40; i++) cyc(0, 0, 1, -32768);
    chk("minneg_sweep", 32'(state_o), 32'd1);

    // Abort beats start (and tick) while in PULL.
    for (int i = 0; i < LOCK_CNT; i++) cyc(0, 0, 1, -512);
    chk("pre_abort_pull", 32'(state_o), 32'd2);
    cyc(1, 1, 1, 0);
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);

    // Asynchronous reset mid-sweep, between clock edges.
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 100; i++) cyc(0, 0, 1, 2000);
    chk("pre_rst_freq", freq_o, 32'h0110_0000);
    start_i = 1'b0; abort_i = 1'b0; tick = 1'b0; error_i = '0;
    #2 rst = 1'b1;
    #1 check_reset_values("async_rst");
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Randomized traffic.
    mode_in = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 59) == 0) mode_in = ~mode_in;
      if (mode_in) err = int'($urandom_range(0, 1024)) - 512;
      else begin
        case ($urandom_range(0, 3))
          0: err = -32768;
          1: err = 513;
          2: err = -513;
          default: err = int'($urandom_range(0, 65535)) - 32768;
        endcase
      end
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 499) == 0,
          $urandom_range(0, 2) != 0, err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
